// File: rtl/harvos_dma_copy_engine.sv
// rtl/harvos_dma_copy_engine.sv - single-channel memory-to-memory word-copy DMA engine
// Reads one word, writes it, advances; exits on done, fault, timeout or abort.
module harvos_dma_copy_engine #(
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_en,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_done,
    input  logic        m_fault,
    output logic        irq
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT
    } state_t;

    state_t state, state_n;

    logic [31:0]      src_reg, dst_reg, fault_addr;
    logic [LEN_W-1:0] len_reg;
    logic             irq_en;
    logic             st_done, st_fault, st_timeout, st_aborted;
    logic [31:0]      src_cnt, dst_cnt, data_reg;
    logic [LEN_W-1:0] remain;
    logic             abort_pending;
    logic [TW-1:0]    to_cnt;

    logic cfg_wr, ctrl_wr, start_cmd, abort_cmd, busy, timeout_hit;
    logic ev_load, ev_zero_done, ev_capture, ev_advance;
    logic ev_complete, ev_fault, ev_timeout, ev_abort_exit;

    assign cfg_wr    = cfg_en & cfg_we;
    assign ctrl_wr   = cfg_wr && (cfg_addr == 4'd0);
    // ABORT beats START when both are written together.
    assign start_cmd = ctrl_wr & cfg_wdata[0] & ~cfg_wdata[1];
    assign abort_cmd = ctrl_wr & cfg_wdata[1];
    assign busy      = (state != IDLE);
    assign timeout_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_n       = state;
        ev_load       = 1'b0;
        ev_zero_done  = 1'b0;
        ev_capture    = 1'b0;
        ev_advance    = 1'b0;
        ev_complete   = 1'b0;
        ev_fault      = 1'b0;
        ev_timeout    = 1'b0;
        ev_abort_exit = 1'b0;
        case (state)
            IDLE: begin
                if (start_cmd) begin
                    ev_load = 1'b1;
                    if (len_reg == '0) begin
                        ev_zero_done = 1'b1;
                    end else begin
                        state_n = RD_REQ;
                    end
                end
            end
            RD_REQ: state_n = RD_WAIT;
            RD_WAIT: begin
                if (m_done) begin
                    if (m_fault) begin
                        ev_fault = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        ev_capture = 1'b1;
                        if (abort_pending) begin
                            ev_abort_exit = 1'b1;
                            state_n       = IDLE;
                        end else begin
                            state_n = WR_REQ;
                        end
                    end
                end else if (timeout_hit) begin
                    ev_fault   = 1'b1;
                    ev_timeout = 1'b1;
                    state_n    = IDLE;
                end
            end
            WR_REQ: state_n = WR_WAIT;
            WR_WAIT: begin
                if (m_done) begin
                    if (m_fault) begin
                        ev_fault = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        ev_advance = 1'b1;
                        if (remain == LEN_W'(1)) begin
                            ev_complete = 1'b1;
                            state_n     = IDLE;
                        end else if (abort_pending) begin
                            ev_abort_exit = 1'b1;
                            state_n       = IDLE;
                        end else begin
                            state_n = RD_REQ;
                        end
                    end
                end else if (timeout_hit) begin
                    ev_fault   = 1'b1;
                    ev_timeout = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign m_req   = (state == RD_REQ) || (state == WR_REQ);
    assign m_we    = (state == WR_REQ) || (state == WR_WAIT);
    assign m_be    = 4'hF;
    assign m_addr  = m_we ? dst_cnt : src_cnt;
    assign m_wdata = data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            src_reg       <= '0;
            dst_reg       <= '0;
            len_reg       <= '0;
            irq_en        <= 1'b0;
            st_done       <= 1'b0;
            st_fault      <= 1'b0;
            st_timeout    <= 1'b0;
            st_aborted    <= 1'b0;
            fault_addr    <= '0;
            src_cnt       <= '0;
            dst_cnt       <= '0;
            data_reg      <= '0;
            remain        <= '0;
            abort_pending <= 1'b0;
            to_cnt        <= '0;
            irq           <= 1'b0;
        end else begin
            state <= state_n;

            if (cfg_wr && !busy) begin
                case (cfg_addr)
                    4'd2: src_reg <= {cfg_wdata[31:2], 2'b00};
                    4'd3: dst_reg <= {cfg_wdata[31:2], 2'b00};
                    4'd4: len_reg <= cfg_wdata[LEN_W-1:0];
                    default: ;
                endcase
            end
            if (ctrl_wr) begin
                irq_en <= cfg_wdata[2];
            end

            // W1C first; engine events below take precedence in the same cycle.
            if (cfg_wr && (cfg_addr == 4'd1)) begin
                if (cfg_wdata[1]) st_done    <= 1'b0;
                if (cfg_wdata[2]) st_fault   <= 1'b0;
                if (cfg_wdata[3]) st_timeout <= 1'b0;
                if (cfg_wdata[4]) st_aborted <= 1'b0;
            end
            if (ev_load) begin
                st_done    <= ev_zero_done;
                st_fault   <= 1'b0;
                st_timeout <= 1'b0;
                st_aborted <= 1'b0;
                src_cnt    <= src_reg;
                dst_cnt    <= dst_reg;
                remain     <= len_reg;
            end
            if (ev_complete)   st_done    <= 1'b1;
            if (ev_timeout)    st_timeout <= 1'b1;
            if (ev_abort_exit) st_aborted <= 1'b1;
            if (ev_fault) begin
                st_fault   <= 1'b1;
                fault_addr <= m_addr;
            end

            if (ev_capture) begin
                data_reg <= m_rdata;
            end
            if (ev_advance) begin
                src_cnt <= src_cnt + 32'd4;
                dst_cnt <= dst_cnt + 32'd4;
                remain  <= remain - 1'b1;
            end

            if (state_n == IDLE) begin
                abort_pending <= 1'b0;
            end else if (abort_cmd && busy) begin
                abort_pending <= 1'b1;
            end

            // Every WAIT is entered from a REQ state, so the count starts at zero.
            if ((state == RD_WAIT) || (state == WR_WAIT)) begin
                to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end

            irq <= irq_en & (st_done | st_fault | st_aborted);
        end
    end

    always_comb begin
        cfg_rdata = 32'd0;
        case (cfg_addr)
            4'd0: cfg_rdata = {29'd0, irq_en, 2'b00};
            4'd1: cfg_rdata = {27'd0, st_aborted, st_timeout, st_fault, st_done, busy};
            4'd2: cfg_rdata = src_reg;
            4'd3: cfg_rdata = dst_reg;
            4'd4: cfg_rdata = 32'(len_reg);
            4'd5: cfg_rdata = fault_addr;
            4'd6: cfg_rdata = 32'(remain);
            default: cfg_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_harvos_dma_copy_engine.sv
// tb/tb_harvos_dma_copy_engine.sv - randomized self-checking bench with transaction-list reference model
module tb_harvos_dma_copy_engine;

    localparam int LEN_W = 16;
    localparam int TO    = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_en = 1'b0, cfg_we = 1'b0;
    logic [3:0]  cfg_addr = 4'd0;
    logic [31:0] cfg_wdata = 32'd0;
    logic [31:0] cfg_rdata;
    logic        m_req, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = 32'd0;
    logic        m_done = 1'b0, m_fault = 1'b0;
    logic        irq;

    always #5 clk = ~clk;

    harvos_dma_copy_engine #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_en(cfg_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_done(m_done),
        .m_fault(m_fault), .irq(irq)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } tx_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Bus slave: logs every request, answers after resp_delay cycles.
    tx_t log_q[$];
    tx_t cur;
    int  cur_idx = -1;
    int  resp_delay = 1;
    int  resp_cnt = -1;
    int  fault_idx = -1;
    int  proto_err = 0;
    bit  withhold = 1'b0;
    bit  late_done = 1'b0;
    bit  outstanding = 1'b0;

    always @(negedge clk) begin
        m_done  = 1'b0;
        m_fault = 1'b0;
        if (m_req) begin
            if (outstanding) proto_err++;
            if (m_be !== 4'hF) proto_err++;
            cur.we    = m_we;
            cur.addr  = m_addr;
            cur.wdata = m_wdata;
            log_q.push_back(cur);
            cur_idx     = log_q.size() - 1;
            outstanding = 1'b1;
            resp_cnt    = withhold ? -1 : resp_delay;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
        end
        if (resp_cnt == 0 || late_done) begin
            m_done      = 1'b1;
            m_fault     = !late_done && (cur_idx == fault_idx);
            m_rdata     = cur.we ? 32'hDEAD_BEEF : mem_word(cur.addr);
            resp_cnt    = -1;
            late_done   = 1'b0;
            outstanding = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_en = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cfg_read(4'd1, s);
            if (!s[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("busy_bound", 32'd1, 32'd0);
    endtask

    task automatic do_transfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                               input int delay, input int fidx, input bit ien, input bit poke);
        tx_t exp_q[$];
        tx_t t;
        logic [31:0] rd, exp_st, exp_rem;
        int n;
        resp_delay = delay;
        fault_idx  = fidx;
        cfg_write(4'd2, src);
        cfg_write(4'd3, dst);
        cfg_write(4'd4, 32'(len));
        log_q.delete();
        cfg_write(4'd0, {29'd0, ien, 2'b01});
        check_val("first_req", {31'd0, m_req}, 32'd1);
        if (poke) begin
            cfg_write(4'd2, 32'h1234_5678);
            cfg_write(4'd4, 32'd9);
        end
        wait_idle();
        tick(2);

        for (int i = 0; i < len; i++) begin
            t.we = 1'b0; t.addr = src + 32'(4 * i); t.wdata = 32'd0;
            exp_q.push_back(t);
            if (fidx == exp_q.size() - 1) break;
            t.we = 1'b1; t.addr = dst + 32'(4 * i); t.wdata = mem_word(src + 32'(4 * i));
            exp_q.push_back(t);
            if (fidx == exp_q.size() - 1) break;
        end

        check_val("tx_count", 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("tx%0d_we", i), {31'd0, log_q[i].we}, {31'd0, exp_q[i].we});
            check_val($sformatf("tx%0d_addr", i), log_q[i].addr, exp_q[i].addr);
            if (exp_q[i].we) check_val($sformatf("tx%0d_wdata", i), log_q[i].wdata, exp_q[i].wdata);
        end

        exp_st  = (fidx >= 0) ? 32'h4 : 32'h2;
        exp_rem = (fidx >= 0) ? 32'(len - fidx / 2) : 32'd0;
        cfg_read(4'd1, rd); check_val("status", rd, exp_st);
        cfg_read(4'd6, rd); check_val("remain", rd, exp_rem);
        if (fidx >= 0) begin
            cfg_read(4'd5, rd); check_val("fault_addr", rd, exp_q[fidx].addr);
        end
        check_val("irq", {31'd0, irq}, {31'd0, ien});
        if (poke) begin
            cfg_read(4'd2, rd); check_val("src_hold", rd, src);
            cfg_read(4'd4, rd); check_val("len_hold", rd, 32'(len));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int k;
        int len, fidx;
        logic [31:0] src, dst;

        tick(3);
        check_val("rst_m_req", {31'd0, m_req}, 32'd0);
        check_val("rst_m_we", {31'd0, m_we}, 32'd0);
        check_val("rst_m_addr", m_addr, 32'd0);
        check_val("rst_m_wdata", m_wdata, 32'd0);
        check_val("rst_irq", {31'd0, irq}, 32'd0);
        check_val("m_be", {28'd0, m_be}, 32'hF);
        for (int a = 0; a < 8; a++) begin
            cfg_read(4'(a), rd);
            check_val($sformatf("rst_reg%0d", a), rd, 32'd0);
        end
        #2 rst_n = 1'b1;

        cfg_write(4'd7, 32'hFFFF_FFFF); cfg_read(4'd7, rd); check_val("unmapped", rd, 32'd0);
        cfg_write(4'd5, 32'hFFFF_FFFF); cfg_read(4'd5, rd); check_val("fault_addr_ro", rd, 32'd0);
        cfg_write(4'd2, 32'h0000_4003); cfg_read(4'd2, rd); check_val("src_align", rd, 32'h4000);

        // Basic three-word copy.
        do_transfer(32'h4000, 32'h5000, 3, 2, -1, 1'b1, 1'b0);

        // Zero-length start.
        cfg_write(4'd4, 32'd0);
        log_q.delete();
        cfg_write(4'd0, 32'h1);
        cfg_read(4'd1, rd); check_val("len0_status", rd, 32'h2);
        tick(5);
        check_val("len0_no_req", 32'(log_q.size()), 32'd0);

        // Fault on the second write, then clear it.
        do_transfer(32'h4000, 32'h5000, 4, 2, 3, 1'b1, 1'b0);
        cfg_write(4'd1, 32'h4);
        tick(2);
        cfg_read(4'd1, rd); check_val("w1c_status", rd, 32'd0);
        check_val("w1c_irq", {31'd0, irq}, 32'd0);

        // Timeout on the first read.
        withhold = 1'b1;
        fault_idx = -1;
        cfg_write(4'd2, 32'h6000);
        cfg_write(4'd4, 32'd2);
        log_q.delete();
        cfg_write(4'd0, 32'h1);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            cfg_read(4'd1, rd);
            if (rd[2]) begin
                k = i;
                break;
            end
        end
        check_val("timeout_latency", 32'(k), 32'(TO + 1));
        cfg_read(4'd1, rd); check_val("timeout_status", rd, 32'hC);
        cfg_read(4'd5, rd); check_val("timeout_addr", rd, 32'h6000);
        withhold = 1'b0;
        late_done = 1'b1;
        tick(4);
        cfg_read(4'd1, rd); check_val("late_done_status", rd, 32'hC);
        cfg_read(4'd6, rd); check_val("timeout_remain", rd, 32'd2);
        check_val("timeout_reqs", 32'(log_q.size()), 32'd1);

        // Abort during the read of word 2 of 5.
        resp_delay = 3;
        cfg_write(4'd2, 32'h7000);
        cfg_write(4'd3, 32'h8000);
        cfg_write(4'd4, 32'd5);
        log_q.delete();
        cfg_write(4'd0, 32'h5);
        k = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (log_q.size() >= 3) begin
                k = 1;
                break;
            end
        end
        check_val("abort_reach", 32'(k), 32'd1);
        cfg_write(4'd0, 32'h6);
        wait_idle();
        tick(3);
        check_val("abort_reqs", 32'(log_q.size()), 32'd3);
        cfg_read(4'd1, rd); check_val("abort_status", rd, 32'h10);
        cfg_read(4'd6, rd); check_val("abort_remain", rd, 32'd4);
        check_val("abort_irq", {31'd0, irq}, 32'd1);

        // START together with ABORT in IDLE does nothing.
        log_q.delete();
        cfg_write(4'd0, 32'h7);
        tick(5);
        check_val("start_abort_reqs", 32'(log_q.size()), 32'd0);
        cfg_read(4'd1, rd); check_val("start_abort_status", rd, 32'h10);

        // Address wrap with config pokes while busy.
        do_transfer(32'hFFFF_FFFC, 32'h0000_0100, 2, 4, -1, 1'b0, 1'b1);

        // Randomized transfers against the model.
        for (int it = 0; it < 10; it++) begin
            src  = {$urandom(), 2'b00} >> 0;
            src[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) src = 32'hFFFF_FFF0 + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
            dst  = $urandom();
            dst[1:0] = 2'b00;
            len  = $urandom_range(1, 6);
            fidx = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, 2 * len - 1);
            do_transfer(src, dst, len, $urandom_range(1, 4), fidx, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset in the middle of a transfer.
        resp_delay = 3;
        fault_idx = -1;
        cfg_write(4'd4, 32'd5);
        cfg_write(4'd0, 32'h5);
        tick(6);
        #2 rst_n = 1'b0;
        resp_cnt = -1;
        outstanding = 1'b0;
        #1;
        check_val("mid_rst_m_req", {31'd0, m_req}, 32'd0);
        cfg_read(4'd1, rd); check_val("mid_rst_status", rd, 32'd0);
        cfg_read(4'd6, rd); check_val("mid_rst_remain", rd, 32'd0);
        cfg_read(4'd4, rd); check_val("mid_rst_len", rd, 32'd0);
        tick(2);
        #2 rst_n = 1'b1;
        tick(3);
        check_val("mid_rst_irq", {31'd0, irq}, 32'd0);

        check_val("protocol", 32'(proto_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/harvos_dma_copy_engine.md
Name: harvos_dma_copy_engine

Overview:
- Single-channel, memory-to-memory word-copy DMA controller for the HarvOS dmem fabric.
- Sequences read/write transactions on a dmem-style master port that feeds the DMA firewall slave side.
- Handles firewall fault responses, bus timeouts, software abort and a completion interrupt.
- Software programs it through a small register port that uses the same cfg_* convention as the firewall.

Parameters:
- LEN_W, 16, width of the word-count register; maximum transfer is 2^LEN_W-1 words.
- TIMEOUT_CYCLES, 255, number of cycles in a WAIT state without m_done before a timeout fault; must be ≥1.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- cfg_en  input  1  config access strobe
- cfg_we  input  1  config write (with cfg_en)
- cfg_addr  input  4  register index
- cfg_wdata  input  32  config write data
- cfg_rdata  output  32  combinational readback of the register at cfg_addr
- m_req  output  1  transaction request, one-cycle pulse
- m_we  output  1  1 = write, 0 = read
- m_be  output  4  byte enables, always 4'hF
- m_addr  output  32  word-aligned address
- m_wdata  output  32  write data
- m_rdata  input  32  read data, valid with m_done on reads
- m_done  input  1  transaction complete, one-cycle pulse
- m_fault  input  1  transaction faulted, qualified by m_done
- irq  output  1  level interrupt

Behaviour:
- Reset: state IDLE; all registers 0; m_req=0, m_we=0, m_addr=0, m_wdata=0, irq=0. m_be is constant 4'hF.
- Register map (any other index reads 0 and ignores writes):
  - 0 CTRL: bit0 START (write-1, self-clearing), bit1 ABORT (write-1, self-clearing), bit2 IRQ_EN (r/w).
  - 1 STATUS: bit0 BUSY (read-only), bit1 DONE, bit2 FAULT, bit3 TIMEOUT, bit4 ABORTED. Bits 1–4 are write-1-to-clear.
  - 2 SRC, 3 DST: bits[1:0] are forced to 0 on write.
  - 4 LEN: word count, LEN_W bits, zero-extended on read.
  - 5 FAULT_ADDR: read-only.
  - 6 REMAIN: read-only count of words left.
- Writes to SRC, DST and LEN while BUSY are ignored. SRC, DST and LEN are never modified by the engine; working copies are held in separate counters.
- START while BUSY is ignored. If START and ABORT are written in the same cycle, ABORT wins and START is ignored.
- START in IDLE: clears STATUS bits 1–4, loads the working src, dst and remain counters, and sets BUSY.
  - If LEN=0: DONE is set in the same edge and BUSY stays 0. No bus access occurs.
  - Otherwise the engine enters RD_REQ.
- RD_REQ: m_req=1, m_we=0, m_addr=src. Next state is RD_WAIT. The first m_req appears in the cycle after the START write edge.
- RD_WAIT: wait for m_done.
  - m_done with m_fault=0: capture m_rdata into the data register, then go to WR_REQ.
  - m_done with m_fault=1: go to the fault exit.
- WR_REQ: m_req=1, m_we=1, m_addr=dst, m_wdata=data register. Next state is WR_WAIT.
- WR_WAIT: on m_done without fault:
  - src += 4 and dst += 4, both wrapping mod 2^32; remain -= 1.
  - If remain reaches 0: set DONE, clear BUSY, go to IDLE.
  - Else if an abort is pending: set ABORTED, clear BUSY, go to IDLE.
  - Else go to RD_REQ.
- m_req is high only in the RD_REQ and WR_REQ states, exactly one cycle each. No new request is issued before the outstanding m_done.
- Fault exit: FAULT_ADDR = the faulting m_addr; set FAULT; clear BUSY; go to IDLE. remain keeps the untransferred count, including the faulting word.
- Timeout:
  - A cycle counter clears on entry to either WAIT state.
  - When it reaches TIMEOUT_CYCLES without m_done, the engine sets FAULT and TIMEOUT, records FAULT_ADDR, and goes to IDLE.
  - If m_done arrives in the same cycle as the timeout, m_done wins.
  - A stray m_done received in IDLE is ignored.
- ABORT while BUSY:
  - Sets abort-pending.
  - Any outstanding transaction is allowed to complete; in-flight bus requests are never dropped.
  - A read that completes while abort is pending goes straight to IDLE with ABORTED set and no write issued.
  - A fault that occurs while abort is pending takes priority: FAULT is set, not ABORTED.
- ABORT in IDLE has no effect.
- irq = IRQ_EN & (DONE | FAULT | ABORTED), registered.
- Reset asserted mid-transfer returns everything to reset values immediately; no completion is reported.

Test Plan:
- SRC=0x4000, DST=0x5000, LEN=3, START, bus done 2 cycles after each req → reads at 0x4000/4004/4008, each followed by a write to 0x5000/5004/5008 carrying that read's data; DONE=1, REMAIN=0, irq=1 when IRQ_EN=1.
- LEN=0, START → DONE=1 on the next cycle, no m_req ever asserted, BUSY=0.
- LEN=4 with m_fault returned on the second write (dst 0x5004) → FAULT=1, FAULT_ADDR=0x5004, REMAIN=3, no further m_req; W1C of STATUS bit2 clears FAULT and drops irq.
- m_done withheld after the first read req with TIMEOUT_CYCLES=8 → FAULT=1 and TIMEOUT=1 exactly 8 cycles after entering RD_WAIT; a late m_done is ignored.
- ABORT written while in RD_WAIT of word 2 of 5 → m_done is accepted, no write is issued, ABORTED=1, REMAIN=4; START+ABORT written together in IDLE → no transfer starts.
- SRC=0xFFFFFFFC, LEN=2 → the second read goes to 0x00000000 (wrap); writes to SRC while BUSY leave SRC unchanged on readback.
